multi_frame_buffer: RTL and testbench

- Parametrised successor to the two-bank ping-pong frame store: 2 or 3 frame banks, configurable pixel width.
- The front bank swaps only at frame start and only once the writer has committed a complete frame. This removes tearing and avoids flipping to a half-drawn buffer.
- Sits between the animation writer and the VGA scan-out, in the vgaclk domain.

---
 rtl/frame_buf_pkg.sv | 20 ++
 rtl/fb_bank.sv | 32 +++
 rtl/multi_frame_buffer.sv | 144 ++++++++++++++
 tb/tb_multi_frame_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// rtl/frame_buf_pkg.sv - shared bank-index type, reset indices and NUM_BUF legality check
package frame_buf_pkg;

    localparam int BUF_IDX_W = 2;

    typedef logic [BUF_IDX_W-1:0] buf_idx_t;

    localparam buf_idx_t FRONT_RST = 2'd0;
    localparam buf_idx_t BACK_RST  = 2'd1;

    // With only two banks there is no separate pending bank, so pend parks on bank 0.
    function automatic buf_idx_t pend_rst(input int num_buf);
        return (num_buf == 3) ? 2'd2 : 2'd0;
    endfunction

    function automatic bit num_buf_legal(input int num_buf);
        return (num_buf == 2) || (num_buf == 3);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// rtl/fb_bank.sv - simple dual-port frame bank, synchronous write, registered read
module fb_bank #(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Addresses past DEPTH are dropped on write and read back as zero.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(wr_addr_i) < DEPTH)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (int'(rd_addr_i) < DEPTH) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multi_frame_buffer.sv
// rtl/multi_frame_buffer.sv - double/triple-buffered frame store swapping only at frame start
// Optional FRAME_REPEAT_CNT_EN adds a saturating count of frames re-shown without new content.
module multi_frame_buffer
    import frame_buf_pkg::*;
#(
    parameter int DEPTH   = 768,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int NUM_BUF = 3
) (
    input  logic              vgaclk,
    input  logic              rstN,
    input  logic              frameStart,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData,
    input  logic              we,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              commit,
    output logic              wrReady,
    output logic [1:0]        frontIdx,
    output logic [15:0]       repeatCnt
);

    if (!num_buf_legal(NUM_BUF)) begin : g_bad_num_buf
        $error("multi_frame_buffer: NUM_BUF must be 2 or 3");
    end

    localparam bit       TRIPLE   = (NUM_BUF == 3);
    localparam buf_idx_t PEND_RST = pend_rst(NUM_BUF);

    buf_idx_t front_q, front_d;
    buf_idx_t back_q, back_d;
    buf_idx_t pend_q, pend_d;
    logic     pend_valid_q, pend_valid_d;
    logic     wr_ready_q, wr_ready_d;
    buf_idx_t front_rd_q;
    logic     rd_valid_q;
    logic     commit_ok;

    logic [DATA_W-1:0] bank_rd [NUM_BUF];
    logic [DATA_W-1:0] rd_mux;

    for (genvar i = 0; i < NUM_BUF; i++) begin : g_bank
        fb_bank #(
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_bank (
            .clk_i    (vgaclk),
            .we_i     (we && wr_ready_q && (back_q == buf_idx_t'(i))),
            .wr_addr_i(wrAddr),
            .wr_data_i(wrData),
            .rd_addr_i(rdAddr),
            .rd_data_o(bank_rd[i])
        );
    end

    always_comb begin
        front_d      = front_q;
        back_d       = back_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        wr_ready_d   = wr_ready_q;
        commit_ok    = commit && wr_ready_q;

        if (frameStart && commit_ok) begin
            // Freshest frame goes straight to the screen; any older pending frame is dropped.
            front_d      = back_q;
            back_d       = front_q;
            pend_valid_d = 1'b0;
            wr_ready_d   = 1'b1;
        end else if (commit_ok) begin
            pend_valid_d = 1'b1;
            if (TRIPLE) begin
                pend_d = back_q;
                back_d = pend_q;
            end else begin
                wr_ready_d = 1'b0;
            end
        end else if (frameStart && pend_valid_q) begin
            pend_valid_d = 1'b0;
            if (TRIPLE) begin
                front_d = pend_q;
                pend_d  = front_q;
            end else begin
                front_d    = back_q;
                back_d     = front_q;
                wr_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge vgaclk or negedge rstN) begin
        if (!rstN) begin
            front_q      <= FRONT_RST;
            back_q       <= BACK_RST;
            pend_q       <= PEND_RST;
            pend_valid_q <= 1'b0;
            wr_ready_q   <= 1'b1;
            front_rd_q   <= FRONT_RST;
            rd_valid_q   <= 1'b0;
        end else begin
            front_q      <= front_d;
            back_q       <= back_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            wr_ready_q   <= wr_ready_d;
            front_rd_q   <= front_q;
            rd_valid_q   <= 1'b1;
        end
    end

    // Bank outputs reflect the front index in force at the read edge, hence the delayed copy.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (front_rd_q == buf_idx_t'(i)) begin
                rd_mux = bank_rd[i];
            end
        end
    end

    assign rdData   = rd_valid_q ? rd_mux : '0;
    assign wrReady  = wr_ready_q;
    assign frontIdx = front_q;

`ifdef FRAME_REPEAT_CNT_EN
    logic [15:0] repeat_cnt_q;

    always_ff @(posedge vgaclk or negedge rstN) begin
        if (!rstN) begin
            repeat_cnt_q <= '0;
        end else if (frameStart && !pend_valid_q && !commit_ok && (repeat_cnt_q != 16'hFFFF)) begin
            repeat_cnt_q <= repeat_cnt_q + 16'd1;
        end
    end

    assign repeatCnt = repeat_cnt_q;
`else
    assign repeatCnt = '0;
`endif

endmodule

// File: tb/tb_multi_frame_buffer.sv
// tb/tb_multi_frame_buffer.sv - scoreboard bench for triple- and double-buffered instances
module tb_multi_frame_buffer;

    localparam int DEPTH  = 768;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

`ifdef FRAME_REPEAT_CNT_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    localparam int S_FI3 = 0, S_RD3 = 1, S_RDY3 = 2, S_RC3 = 3;
    localparam int S_FI2 = 4, S_RD2 = 5, S_RDY2 = 6, S_RC2 = 7;

    logic vgaclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 vgaclk = ~vgaclk;

    logic              fs3 = 1'b0, cm3 = 1'b0, we3 = 1'b0;
    logic [ADDR_W-1:0] ra3 = '0, wa3 = '0;
    logic [DATA_W-1:0] wd3 = '0;
    logic [DATA_W-1:0] rd3;
    logic              rdy3;
    logic [1:0]        fi3;
    logic [15:0]       rc3;

    logic              fs2 = 1'b0, cm2 = 1'b0, we2 = 1'b0;
    logic [ADDR_W-1:0] ra2 = '0, wa2 = '0;
    logic [DATA_W-1:0] wd2 = '0;
    logic [DATA_W-1:0] rd2;
    logic              rdy2;
    logic [1:0]        fi2;
    logic [15:0]       rc2;

    multi_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BUF(3)) u_triple (
        .vgaclk(vgaclk), .rstN(rst_n), .frameStart(fs3), .rdAddr(ra3), .rdData(rd3),
        .we(we3), .wrAddr(wa3), .wrData(wd3), .commit(cm3), .wrReady(rdy3),
        .frontIdx(fi3), .repeatCnt(rc3)
    );

    multi_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BUF(2)) u_double (
        .vgaclk(vgaclk), .rstN(rst_n), .frameStart(fs2), .rdAddr(ra2), .rdData(rd2),
        .we(we2), .wrAddr(wa2), .wrData(wd2), .commit(cm2), .wrReady(rdy2),
        .frontIdx(fi2), .repeatCnt(rc2)
    );

    typedef struct {
        int          due;
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge vgaclk) cyc <= cyc + 1;

    function automatic logic [15:0] observe(input int sig);
        case (sig)
            S_FI3:   return 16'(fi3);
            S_RD3:   return 16'(rd3);
            S_RDY3:  return 16'(rdy3);
            S_RC3:   return rc3;
            S_FI2:   return 16'(fi2);
            S_RD2:   return 16'(rd2);
            S_RDY2:  return 16'(rdy2);
            default: return rc2;
        endcase
    endfunction

    function automatic logic [15:0] rc_exp(input int n);
        return RC_EN ? 16'(n) : 16'd0;
    endfunction

    task automatic expect_sig(input int sig, input logic [15:0] val, input string name);
        exp_t e;
        e.due  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    always @(negedge vgaclk) begin : monitor
        exp_t        e;
        logic [15:0] act;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e   = exp_q.pop_front();
            act = observe(e.sig);
            n_total++;
            if (act === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic tick;
        @(posedge vgaclk);
        #1;
    endtask

    task automatic write3(input int addr, input logic [DATA_W-1:0] data);
        we3 = 1'b1; wa3 = ADDR_W'(addr); wd3 = data;
        tick();
        we3 = 1'b0;
    endtask

    task automatic write2(input int addr, input logic [DATA_W-1:0] data);
        we2 = 1'b1; wa2 = ADDR_W'(addr); wd2 = data;
        tick();
        we2 = 1'b0;
    endtask

    task automatic expect_reset(input string tag);
        expect_sig(S_FI3, 16'd0, {tag, "_fi3"});
        expect_sig(S_RDY3, 16'd1, {tag, "_rdy3"});
        expect_sig(S_RD3, 16'd0, {tag, "_rd3"});
        expect_sig(S_RC3, 16'd0, {tag, "_rc3"});
        expect_sig(S_FI2, 16'd0, {tag, "_fi2"});
        expect_sig(S_RDY2, 16'd1, {tag, "_rdy2"});
        expect_sig(S_RD2, 16'd0, {tag, "_rd2"});
        expect_sig(S_RC2, 16'd0, {tag, "_rc2"});
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        expect_reset("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // No commits: every frame start repeats bank 0.
        for (int k = 0; k < 3; k++) begin
            fs3 = 1'b1; fs2 = 1'b1;
            tick();
            fs3 = 1'b0; fs2 = 1'b0;
            expect_sig(S_FI3, 16'd0, "repeat_fi3");
            expect_sig(S_FI2, 16'd0, "repeat_fi2");
            tick();
        end
        expect_sig(S_RC3, rc_exp(3), "repeat_cnt3");
        expect_sig(S_RC2, rc_exp(3), "repeat_cnt2");

        // Triple: fill bank 1 with AA, commit, swap.
        for (int i = 0; i < DEPTH; i++) begin
            we3 = 1'b1; wa3 = ADDR_W'(i); wd3 = 8'hAA;
            tick();
        end
        we3 = 1'b0;
        cm3 = 1'b1;
        tick();
        cm3 = 1'b0;
        expect_sig(S_RDY3, 16'd1, "t3_commit_rdy");
        expect_sig(S_FI3, 16'd0, "t3_commit_no_swap");
        fs3 = 1'b1; ra3 = ADDR_W'(5);
        tick();
        fs3 = 1'b0;
        expect_sig(S_FI3, 16'd1, "t3_swap_fi");
        tick();
        expect_sig(S_RD3, 16'hAA, "t3_swap_rd_aa");

        // Writer now targets bank 2.
        write3(5, 8'h33);
        cm3 = 1'b1;
        tick();
        cm3 = 1'b0; fs3 = 1'b1;
        tick();
        fs3 = 1'b0;
        expect_sig(S_FI3, 16'd2, "t3_bank2_fi");
        tick();
        expect_sig(S_RD3, 16'h33, "t3_bank2_rd");

        // Two commits before one frame start: the newer frame is shown.
        for (int i = 0; i < 8; i++) write3(i, 8'h11);
        cm3 = 1'b1;
        tick();
        cm3 = 1'b0;
        expect_sig(S_RDY3, 16'd1, "t3_c1_rdy");
        for (int i = 0; i < 8; i++) write3(i, 8'h22);
        cm3 = 1'b1;
        tick();
        cm3 = 1'b0;
        expect_sig(S_RDY3, 16'd1, "t3_c2_rdy");
        expect_sig(S_FI3, 16'd2, "t3_c2_no_swap");
        fs3 = 1'b1; ra3 = ADDR_W'(3);
        tick();
        fs3 = 1'b0;
        expect_sig(S_FI3, 16'd1, "t3_newest_fi");
        tick();
        expect_sig(S_RD3, 16'h22, "t3_newest_rd");

        // Commit and frame start on the same edge; read edge straddles the swap.
        write3(6, 8'h44);
        ra3 = ADDR_W'(6); cm3 = 1'b1; fs3 = 1'b1;
        tick();
        cm3 = 1'b0; fs3 = 1'b0;
        expect_sig(S_FI3, 16'd0, "t3_simul_fi");
        expect_sig(S_RD3, 16'h22, "t3_simul_old_rd");
        expect_sig(S_RC3, rc_exp(3), "t3_simul_not_repeat");
        tick();
        expect_sig(S_RD3, 16'h44, "t3_simul_new_rd");
        fs3 = 1'b1;
        tick();
        fs3 = 1'b0;
        expect_sig(S_FI3, 16'd0, "t3_simul_pend_clear");
        expect_sig(S_RC3, rc_exp(4), "t3_repeat_after");

        // Double: commit stalls the writer until the swap.
        write2(0, 8'h77);
        cm2 = 1'b1;
        tick();
        cm2 = 1'b0;
        expect_sig(S_RDY2, 16'd0, "t2_commit_stall");
        we2 = 1'b1; wa2 = '0; wd2 = 8'h55; cm2 = 1'b1;
        tick();
        we2 = 1'b0; cm2 = 1'b0;
        expect_sig(S_RDY2, 16'd0, "t2_still_stalled");
        expect_sig(S_FI2, 16'd0, "t2_no_swap_yet");
        fs2 = 1'b1; ra2 = '0;
        tick();
        fs2 = 1'b0;
        expect_sig(S_FI2, 16'd1, "t2_swap_fi");
        expect_sig(S_RDY2, 16'd1, "t2_swap_rdy");
        tick();
        expect_sig(S_RD2, 16'h77, "t2_dropped_write");
        expect_sig(S_RC2, rc_exp(3), "t2_repeat_unchanged");
        write2(0, 8'h88);
        cm2 = 1'b1;
        tick();
        cm2 = 1'b0; fs2 = 1'b1;
        tick();
        fs2 = 1'b0;
        expect_sig(S_FI2, 16'd0, "t2_swap_back_fi");
        tick();
        expect_sig(S_RD2, 16'h88, "t2_swap_back_rd");

        // Set up non-reset state on both, then reset mid-frame.
        cm2 = 1'b1;
        tick();
        cm2 = 1'b0;
        expect_sig(S_RDY2, 16'd0, "pre_rst_rdy2");
        cm3 = 1'b1;
        tick();
        cm3 = 1'b0; fs3 = 1'b1; ra3 = ADDR_W'(6);
        tick();
        fs3 = 1'b0;
        expect_sig(S_FI3, 16'd1, "pre_rst_fi3");
        tick();
        expect_sig(S_RD3, 16'h22, "pre_rst_rd3");
        tick();
        rst_n = 1'b0;
        expect_reset("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) tick();
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
            n_total += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
